mm_front_end_reader: RTL

//  Input side of the memory-mapped coprocessor: after start, reads 'size' words

---
 rtl/mm_front_end_pkg.sv | 16 +
 rtl/mm_front_end_reader_if.sv | 26 ++
 rtl/mm_fe_skid_buf.sv | 57 +++++
 rtl/mm_front_end_reader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mm_front_end_pkg.sv
// Shared types and sizing for the memory-mapped front-end reader.
// Holds the FSM state encoding and the depth of the output skid buffer.
package mm_front_end_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } fe_state_t;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int BUF_PTR_W = $clog2(BUF_DEPTH);

endpackage

// File: rtl/mm_front_end_reader_if.sv
// BRAM read port plus the valid/ready output stream of the front-end reader.
// master = reader side; slave = memory and accelerator side.
interface mm_front_end_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_en, mem_addr, out_data, out_valid, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_data, out_valid, out_last,
    output mem_rdata, out_ready
  );

endinterface

// File: rtl/mm_fe_skid_buf.sv
// Two-entry first-word-fall-through FIFO of {last, data} with an empty-bypass path,
// so a word arriving from the BRAM is visible on the stream in the same cycle.
module mm_fe_skid_buf
  import mm_front_end_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 push,
  input  logic                 push_last,
  input  logic [DATA_W-1:0]    push_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic [BUF_CNT_W-1:0] count
);

  logic [DATA_W:0]    mem [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr;
  logic [BUF_PTR_W-1:0] rd_ptr;
  logic               head_valid;
  logic               pop;
  logic               store;
  logic               deq;

  // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    head_valid = (count != '0);
    out_valid  = head_valid | push;
    {out_last, out_data} = head_valid ? mem[rd_ptr] : {push_last, push_data};
    pop   = out_valid & out_ready;
    // An incoming word taken straight through the bypass is never stored.
    store = push & ~(~head_valid & pop);
    deq   = head_valid & pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + BUF_PTR_W'(1);
      if (deq)   rd_ptr <= rd_ptr + BUF_PTR_W'(1);
      count <= count + BUF_CNT_W'(store) - BUF_CNT_W'(deq);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge aclk) begin
    if (store) mem[wr_ptr] <= {push_last, push_data};
  end

endmodule

// File: rtl/mm_front_end_reader.sv
// Front-end reader: streams 'size' words from local BRAM to the accelerator input.
// Optional macro MM_FE_BASE_ADDR_EN adds a base_addr port; otherwise reads start at 0.
module mm_front_end_reader
  import mm_front_end_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [ADDR_W:0]     size,
`ifdef MM_FE_BASE_ADDR_EN
  input  logic [ADDR_W-1:0]   base_addr,
`endif
  mm_front_end_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  fe_state_t            state;
  logic [ADDR_W:0]      size_q;
  logic [ADDR_W:0]      rd_cnt;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W-1:0]    start_base;
  logic                 inflight;
  logic                 inflight_last;
  logic [BUF_CNT_W-1:0] buf_count;
  logic [BUF_CNT_W:0]   occupancy;
  logic                 mem_en;
  logic                 issue_last;
  logic                 accept_last;
  logic                 s_valid;
  logic                 s_last;
  logic [DATA_W-1:0]    s_data;

`ifdef MM_FE_BASE_ADDR_EN
  assign start_base = base_addr;
`else
  assign start_base = '0;
`endif

  always_comb begin
    // Reads already in flight count against buffer space so nothing can overflow.
    occupancy   = {1'b0, buf_count} + (BUF_CNT_W+1)'(inflight);
    mem_en      = (state == READ) && (rd_cnt < size_q) &&
                  (occupancy < (BUF_CNT_W+1)'(BUF_DEPTH));
    issue_last  = (rd_cnt == size_q - (ADDR_W+1)'(1));
    accept_last = s_valid & bus.out_ready & s_last;
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = base_q + rd_cnt[ADDR_W-1:0];
  assign bus.out_valid = s_valid;
  assign bus.out_last  = s_last;
  assign bus.out_data  = s_data;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      size_q        <= '0;
      rd_cnt        <= '0;
      base_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= mem_en;
      inflight_last <= mem_en & issue_last;
      done          <= 1'b0;
      if (mem_en) rd_cnt <= rd_cnt + (ADDR_W+1)'(1);

      unique case (state)
        IDLE: begin
          if (start) begin
            size_q <= size;
            rd_cnt <= '0;
            base_q <= start_base;
            if (size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (mem_en && issue_last) state <= DRAIN;
        end
        DRAIN: begin
          if (accept_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mm_fe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .aclk      (aclk),
    .areset    (areset),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (bus.mem_rdata),
    .out_valid (s_valid),
    .out_last  (s_last),
    .out_data  (s_data),
    .out_ready (bus.out_ready),
    .count     (buf_count)
  );

endmodule
